// File: rtl/wormhole_rr_arbiter.sv
// Wormhole round-robin output arbiter: zero-cycle grant, lock held from head to tail flit.
// Optional lock watchdog built when ARB_LOCK_WATCHDOG_EN is defined; no backpressure of its own.
module wormhole_rr_arbiter #(
    parameter int NUM_PORTS    = 5,
    parameter int LOCK_TIMEOUT = 64,
    parameter int IDX_W        = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] request,
    input  logic                 forwarding_head,
    input  logic                 forwarding_tail,
    output logic [NUM_PORTS-1:0] grant,
    output logic                 grant_valid,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 locked,
    output logic                 lock_timeout
);

    localparam int SW = IDX_W + 1;

    if (NUM_PORTS < 2 || NUM_PORTS > 16) begin : g_bad_ports
        $error("wormhole_rr_arbiter: NUM_PORTS must be in 2..16");
    end
    if (IDX_W != $clog2(NUM_PORTS)) begin : g_bad_idx_w
        $error("wormhole_rr_arbiter: IDX_W is derived and must not be overridden");
    end
    if (LOCK_TIMEOUT < 2 || LOCK_TIMEOUT > 65535) begin : g_bad_timeout
        $error("wormhole_rr_arbiter: LOCK_TIMEOUT must be in 2..65535");
    end

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic             locked_q, locked_d;

    logic [IDX_W-1:0] arb_idx;
    logic             arb_found;
    logic [SW-1:0]    cand;
    logic             head_acc;
    logic             wd_expire;

    // Cyclic scan from ptr; ptr < NUM_PORTS, so one conditional subtract wraps it.
    always_comb begin
        arb_idx   = '0;
        arb_found = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = {1'b0, ptr_q} + SW'(k);
            if (cand >= SW'(NUM_PORTS)) begin
                cand = cand - SW'(NUM_PORTS);
            end
            if (!arb_found && request[cand[IDX_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign grant_idx   = locked_q ? owner_q : arb_idx;
    assign grant_valid = locked_q ? request[owner_q] : arb_found;
    assign grant       = (locked_q || arb_found) ? (NUM_PORTS'(1) << grant_idx) : '0;
    assign locked      = locked_q;

    assign head_acc = forwarding_head && grant_valid && !locked_q;

    always_comb begin
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        locked_d = locked_q;
        if (head_acc) begin
            ptr_d    = (grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
            owner_d  = grant_idx;
            locked_d = !forwarding_tail;
        end else if (locked_q && forwarding_tail) begin
            locked_d = 1'b0;
        end else if (locked_q && wd_expire) begin
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= '0;
            owner_q  <= '0;
            locked_q <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            locked_q <= locked_d;
        end
    end

`ifdef ARB_LOCK_WATCHDOG_EN
    localparam int WD_W = $clog2(LOCK_TIMEOUT);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            lock_timeout_q, lock_timeout_d;

    // wd_cnt counts completed locked cycles; the LOCK_TIMEOUT-th tail-less one releases.
    assign wd_expire = locked_q && !forwarding_tail && (wd_cnt_q == WD_W'(LOCK_TIMEOUT - 1));

    always_comb begin
        wd_cnt_d       = wd_cnt_q;
        lock_timeout_d = 1'b0;
        if (head_acc) begin
            wd_cnt_d = '0;
        end else if (wd_expire) begin
            wd_cnt_d       = '0;
            lock_timeout_d = 1'b1;
        end else if (locked_q && !forwarding_tail) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q       <= '0;
            lock_timeout_q <= 1'b0;
        end else begin
            wd_cnt_q       <= wd_cnt_d;
            lock_timeout_q <= lock_timeout_d;
        end
    end

    assign lock_timeout = lock_timeout_q;
`else
    assign wd_expire    = 1'b0;
    assign lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wormhole_rr_arbiter.sv
// Bench: 4-port and 5-port arbiters checked every cycle against a queue-free behavioural model plus directed literals.
module tb_wormhole_rr_arbiter;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    always #5 clk = ~clk;

    logic [3:0] req4, g4;
    logic       hd4, tl4, gv4, lk4, lt4;
    logic [1:0] gi4;
    logic [4:0] req5, g5;
    logic       hd5, tl5, gv5, lk5, lt5;
    logic [2:0] gi5;

    wormhole_rr_arbiter #(.NUM_PORTS(4), .LOCK_TIMEOUT(TO)) u_arb4 (
        .clk(clk), .rst(rst), .request(req4),
        .forwarding_head(hd4), .forwarding_tail(tl4),
        .grant(g4), .grant_valid(gv4), .grant_idx(gi4),
        .locked(lk4), .lock_timeout(lt4)
    );

    wormhole_rr_arbiter #(.NUM_PORTS(5), .LOCK_TIMEOUT(TO)) u_arb5 (
        .clk(clk), .rst(rst), .request(req5),
        .forwarding_head(hd5), .forwarding_tail(tl5),
        .grant(g5), .grant_valid(gv5), .grant_idx(gi5),
        .locked(lk5), .lock_timeout(lt5)
    );

    int checks   = 0;
    int failures = 0;

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: priority pointer, lock owner, lock flag, cycles spent locked, pending pulse.
    int m_ptr[2], m_own[2], m_age[2];
    bit m_lk[2], m_pulse[2];
    bit m_on = 1'b0;

    function automatic void model_eval(input int n, input int ptr, input int own, input bit lk,
                                       input logic [15:0] req, output int gidx, output bit gv,
                                       output logic [15:0] g);
        gidx = 0; gv = 1'b0; g = '0;
        if (lk) begin
            gidx = own; gv = req[own]; g = 16'd1 << own;
        end else begin
            for (int k = 0; k < n; k++) begin
                int idx;
                idx = (ptr + k) % n;
                if (req[idx]) begin
                    gidx = idx; gv = 1'b1; g = 16'd1 << idx;
                    break;
                end
            end
        end
    endfunction

    task automatic get_io(input int i, output int n, output logic [15:0] req, output bit hd,
                          output bit tl, output logic [15:0] g, output int gi, output logic gv,
                          output logic lk, output logic lt);
        if (i == 0) begin
            n = 4; req = {12'b0, req4}; hd = hd4; tl = tl4; g = {12'b0, g4};
            gi = int'(gi4); gv = gv4; lk = lk4; lt = lt4;
        end else begin
            n = 5; req = {11'b0, req5}; hd = hd5; tl = tl5; g = {11'b0, g5};
            gi = int'(gi5); gv = gv5; lk = lk5; lt = lt5;
        end
    endtask

    task automatic cmp_inst(input int i);
        int n, gi, egi;
        logic [15:0] req, g, eg;
        bit hd, tl, egv;
        logic gv, lk, lt;
        get_io(i, n, req, hd, tl, g, gi, gv, lk, lt);
        model_eval(n, m_ptr[i], m_own[i], m_lk[i], req, egi, egv, eg);
        lit(i ? "m5_grant" : "m4_grant", g, eg);
        lit(i ? "m5_grant_idx" : "m4_grant_idx", gi, egi);
        lit(i ? "m5_grant_valid" : "m4_grant_valid", gv, egv);
        lit(i ? "m5_locked" : "m4_locked", lk, m_lk[i]);
        lit(i ? "m5_lock_timeout" : "m4_lock_timeout", lt, m_pulse[i]);
        lit(i ? "m5_onehot0" : "m4_onehot0", $onehot0(g), 1);
        lit(i ? "m5_idx_range" : "m4_idx_range", gi < n, 1);
    endtask

    task automatic upd_inst(input int i);
        int n, gi, egi;
        logic [15:0] req, g, eg;
        bit hd, tl, egv, pulse_n;
        logic gv, lk, lt;
        get_io(i, n, req, hd, tl, g, gi, gv, lk, lt);
        if (rst) begin
            m_ptr[i] = 0; m_own[i] = 0; m_lk[i] = 1'b0; m_age[i] = 0; m_pulse[i] = 1'b0;
        end else begin
            model_eval(n, m_ptr[i], m_own[i], m_lk[i], req, egi, egv, eg);
            pulse_n = 1'b0;
            if (!m_lk[i]) begin
                if (hd && egv) begin
                    m_ptr[i] = (egi + 1) % n;
                    m_own[i] = egi;
                    m_lk[i]  = !tl;
                    m_age[i] = 1;
                end
            end else if (tl) begin
                m_lk[i] = 1'b0;
            end else begin
`ifdef ARB_LOCK_WATCHDOG_EN
                if (m_age[i] == TO) begin
                    m_lk[i] = 1'b0;
                    pulse_n = 1'b1;
                end else begin
                    m_age[i]++;
                end
`else
                m_age[i]++;
`endif
            end
            m_pulse[i] = pulse_n;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (m_on) begin
                cmp_inst(0);
                cmp_inst(1);
            end
            @(posedge clk);
            upd_inst(0);
            upd_inst(1);
            if (rst) m_on = 1'b1;
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rr_exp [5];

    initial begin
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b1;
        req4 = '0; hd4 = 1'b0; tl4 = 1'b0;
        req5 = '0; hd5 = 1'b0; tl5 = 1'b0;
        cyc; cyc;
        rst = 1'b0;

        // Zero-cycle grant from reset state
        req4 = 4'b1010;
        @(negedge clk);
        lit("reset_grant", g4, 4'b0010);
        lit("reset_idx", gi4, 1);
        lit("reset_gv", gv4, 1);
        lit("reset_locked", lk4, 0);
        lit("reset_timeout", lt4, 0);
        cyc;

        // Single-flit packets every cycle rotate the grant
        req4 = 4'b1111; hd4 = 1'b1; tl4 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            lit("rr_grant", g4, rr_exp[k]);
            lit("rr_locked", lk4, 0);
            cyc;
        end

        // Lock on input 2 survives bubbles; tail hands over to input 3
        req4 = 4'b0100; hd4 = 1'b1; tl4 = 1'b0;
        @(negedge clk);
        lit("lock_head_grant", g4, 4'b0100);
        cyc;
        hd4 = 1'b0; req4 = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            lit("bubble_grant", g4, 4'b0100);
            lit("bubble_gv", gv4, 0);
            lit("bubble_locked", lk4, 1);
            cyc;
        end
        req4 = 4'b0100; tl4 = 1'b1;
        @(negedge clk);
        lit("tail_gv", gv4, 1);
        cyc;
        tl4 = 1'b0; req4 = 4'b1001;
        @(negedge clk);
        lit("after_tail_grant", g4, 4'b1000);
        lit("after_tail_locked", lk4, 0);
        cyc;

        // Head on input 0 with no tail
        req4 = 4'b0001; hd4 = 1'b1;
        cyc;
        hd4 = 1'b0;
`ifdef ARB_LOCK_WATCHDOG_EN
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            lit("wd_locked", lk4, 1);
            lit("wd_no_pulse", lt4, 0);
            cyc;
        end
        @(negedge clk);
        lit("wd_released", lk4, 0);
        lit("wd_pulse", lt4, 1);
        cyc;
        @(negedge clk);
        lit("wd_pulse_end", lt4, 0);
        cyc;
`else
        for (int k = 0; k < TO + 2; k++) begin
            @(negedge clk);
            lit("nowd_locked", lk4, 1);
            lit("nowd_no_pulse", lt4, 0);
            cyc;
        end
        tl4 = 1'b1;
        cyc;
        tl4 = 1'b0;
`endif

        // Tail in the last allowed locked cycle: normal release, no pulse
        req4 = 4'b0010; hd4 = 1'b1;
        cyc;
        hd4 = 1'b0;
        for (int k = 0; k < TO - 1; k++) begin
            @(negedge clk);
            lit("late_tail_locked", lk4, 1);
            cyc;
        end
        tl4 = 1'b1;
        @(negedge clk);
        lit("late_tail_cycle_locked", lk4, 1);
        cyc;
        tl4 = 1'b0;
        @(negedge clk);
        lit("late_tail_released", lk4, 0);
        lit("late_tail_no_pulse", lt4, 0);
        cyc;

        // Reset mid-packet
        req4 = 4'b0100; hd4 = 1'b1;
        cyc;
        hd4 = 1'b0;
        @(negedge clk);
        lit("pre_rst_locked", lk4, 1);
        cyc;
        rst = 1'b1; req4 = 4'b1111;
        cyc;
        rst = 1'b0;
        @(negedge clk);
        lit("post_rst_locked", lk4, 0);
        lit("post_rst_timeout", lt4, 0);
        lit("post_rst_grant", g4, 4'b0001);
        lit("post_rst_idx", gi4, 0);
        cyc;
        req4 = '0;

        // Five ports: pointer wrap on a non-power-of-2 count
        req5 = 5'b01000; hd5 = 1'b1; tl5 = 1'b1;
        @(negedge clk);
        lit("p5_first_idx", gi5, 3);
        cyc;
        req5 = 5'b00011; hd5 = 1'b0; tl5 = 1'b0;
        @(negedge clk);
        lit("p5_wrap_idx", gi5, 0);
        lit("p5_wrap_grant", g5, 5'b00001);
        cyc;
        req5 = 5'b10000; hd5 = 1'b1; tl5 = 1'b1;
        @(negedge clk);
        lit("p5_top_idx", gi5, 4);
        cyc;
        req5 = 5'b11111; hd5 = 1'b0; tl5 = 1'b0;
        @(negedge clk);
        lit("p5_ptr_wrapped_idx", gi5, 0);
        cyc;
        req5 = '0;
        cyc;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
